pc_sequencer: RTL

//   Produces the PC-select code and the four next-PC candidates consumed by the PC select mux.

---
 rtl/pc_sequencer_pkg.sv | 41 ++++
 rtl/pc_target_calc.sv | 26 ++
 rtl/pc_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: opcode/funct constants, PC-select codes,
// FSM state encoding and the PC-select decode helper.
package pc_sequencer_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_JR     = 2'b11;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_e;

    // Untaken branches and every unrecognised opcode fall through to PC+4.
    function automatic logic [1:0] decode_pcsrc(
        input logic [5:0] op,
        input logic [5:0] funct,
        input logic       zero
    );
        logic [1:0] sel;
        sel = PCSRC_PLUS4;
        case (op)
            OP_BEQ:       if (zero)  sel = PCSRC_BRANCH;
            OP_BNE:       if (!zero) sel = PCSRC_BRANCH;
            OP_J, OP_JAL: sel = PCSRC_JUMP;
            OP_RTYPE:     if (funct == FN_JR) sel = PCSRC_JR;
            default:      sel = PCSRC_PLUS4;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Purely combinational computation of the four next-PC candidates fed to the PC mux.
module pc_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    input  logic [25:0] jindex,
    input  logic [31:0] rs_val,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target,
    output logic [31:0] jr_target
);

    logic [31:0] branch_offset;

    // Branch offset is a sign-extended word offset relative to the delay-free PC+4.
    always_comb begin
        pc_plus4      = pc + 32'd4;
        branch_offset = {{14{imm[15]}}, imm, 2'b00};
        branch_target = pc_plus4 + branch_offset;
        jump_target   = {pc_plus4[31:28], jindex, 2'b00};
        jr_target     = rs_val;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: owns the architectural PC, the retired-instruction counter,
// the sticky misalignment flag and the PC-select decode for the PC mux.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] jindex,
    input  logic        zero,
    input  logic [31:0] rs_val,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target,
    output logic [31:0] jr_target,
    output logic [1:0]  pcsrc,
    output logic        imem_req,
    output logic        misalign_err,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic        misalign_err_q, misalign_err_d;

    pc_target_calc u_target_calc (
        .pc            (pc_q),
        .imm           (imm),
        .jindex        (jindex),
        .rs_val        (rs_val),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target)
    );

    assign pcsrc = decode_pcsrc(op, funct, zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FETCH;
            pc_q           <= RESET_VEC;
            retired_q      <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            retired_q      <= retired_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // The fetch request is masked during the reset cycle itself; a misaligned
    // next PC is redirected to the exception vector and latches the error flag.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        retired_d      = retired_q;
        misalign_err_d = misalign_err_q;
        imem_req       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = !rst;
                if (imem_ready) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        pc_d           = EXC_VEC;
                        misalign_err_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign pc           = pc_q;
    assign retired      = retired_q;
    assign misalign_err = misalign_err_q;

endmodule
